time_keeper: RTL and testbench
==============================

Name: time_keeper

Overview:
- Consumer end of the 1 Hz divider output. Counts elapsed seconds into a BCD 24-hour time of day (hh:mm:ss).
- Samples the divider's toggling square wave `tick_in` through a synchronizer and converts each qualifying edge into one seconds increment.
- Accepts a time-set load through a valid/ready handshake with range checking.
- Drives the display/alarm logic downstream with BCD time and rollover strobes.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the `tick_in` synchronizer; legal range 2..4.
- BOTH_EDGES, 1, 1 = every `tick_in` transition is one second (divider toggles once per second); 0 = rising edges only.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  asynchronous, active-high reset
- tick_in  in  1  divider square wave; asynchronous to nothing, but treated as untrusted and synchronized
- load_valid  in  1  time-set request
- load_ready  out  1  block can accept a load this cycle
- load_hh  in  8  BCD hours {tens[7:4], units[3:0]}
- load_mm  in  8  BCD minutes
- load_ss  in  8  BCD seconds
- load_err  out  1  one-cycle pulse: last accepted load was rejected
- hh  out  8  BCD hours 00..23
- mm  out  8  BCD minutes 00..59
- ss  out  8  BCD seconds 00..59
- sec_pulse  out  1  one-cycle strobe on each seconds increment
- min_pulse  out  1  one-cycle strobe when ss wraps 59->00
- hour_pulse  out  1  one-cycle strobe when mm wraps 59->00
- day_pulse  out  1  one-cycle strobe when hh wraps 23->00

Behaviour:
- Reset (asynchronous, active-high) clears:
  - hh/mm/ss to 00:00:00, all strobes to 0, load_err to 0.
  - Synchronizer flops and the arm counter to 0.
  - FSM to RUN, so load_ready=1 from the first clock after release.
- Arming: edge detection is suppressed for SYNC_STAGES+1 cycles after reset release. This prevents a spurious edge when `tick_in` is already high. After that, the previous-sample register tracks the synchronized value.
- Edge qualification:
  - tick_evt = sync_out XOR prev when BOTH_EDGES=1.
  - tick_evt = sync_out AND NOT prev when BOTH_EDGES=0.
- Latency: a `tick_in` change becomes visible on ss/sec_pulse SYNC_STAGES+2 clk edges later (synchronizer + edge register + time register).
- Increment on tick_evt in RUN:
  - ss units 9 -> 0 with tens carry.
  - ss 59 -> 00 carries into mm; mm 59 -> 00 carries into hh.
  - hh 23 -> 00. Hours units wrap at 9 when tens<2 and at 3 when tens=2.
- All strobes are registered and asserted in the same cycle the new time appears. At 23:59:59 -> 00:00:00, sec/min/hour/day pulses all assert together.
- FSM states:
  - RUN: load_ready=1. On load_valid&&load_ready, capture the three load bytes and go to CHECK.
  - CHECK (1 cycle): load_ready=0. Validate each nibble: units<=9; ss/mm tens<=5; hh tens<=2; hh units<=3 when tens=2.
    - If valid, write hh/mm/ss from the captured bytes at the end of CHECK.
    - Otherwise leave the time unchanged and pulse load_err for one cycle.
    - Return to RUN in both cases.
- Loaded values never assert any strobe.
- Simultaneous events: a tick_evt in the accept cycle or during CHECK is discarded, because the loaded time supersedes it. The time does not increment in that window, and on an invalid load the dropped second is lost by design.
- Load bytes are sampled only in the accept cycle. Changes to them afterward have no effect.
- Reset mid-CHECK aborts the load: time becomes 00:00:00 and no load_err is produced.
- Unsynchronized glitches shorter than one clk period may be missed. This is acceptable for a 1 Hz source.

Decomposition:
- Shared package (clock_pkg): BCD digit width, limit constants SEC_MAX_TENS=5, HOUR_MAX_TENS=2, HOUR_MAX_UNITS_AT_2=3, and FSM state encoding RUN/CHECK.
- Sub-module tick_sync: synchronizer, arm counter and edge detector, outputs tick_evt. It is reused by the display blink logic.
- BCD digit counters stay inline.

Test Plan:
- Reset release with tick_in held high, BOTH_EDGES=1: no sec_pulse within 10 cycles; ss stays 00. A later tick_in 1->0 gives ss=01 exactly SYNC_STAGES+2 cycles after the change.
- Load 23:59:58, then two tick_in toggles: first gives 23:59:59 with sec_pulse only; second gives 00:00:00 with sec/min/hour/day pulses high in the same single cycle.
- Load 09:59:59 then one toggle -> 10:00:00, with sec/min/hour pulses and no day_pulse. Load 19:59:59 + toggle -> 20:00:00.
- Invalid loads:
  - 24:00:00 -> load_err pulse 1 cycle after accept, time unchanged.
  - 12:60:00 rejected.
  - 0x1A:00:00 rejected.
  - load_ready is 0 during CHECK.
- tick_in toggle timed so tick_evt coincides with the accept cycle of load 08:30:00: result is exactly 08:30:00 and no sec_pulse. The next toggle gives 08:30:01.
- BOTH_EDGES=0: four toggles (two rising edges) from 00:00:00 -> ss=02. Assert rst mid-CHECK -> all outputs 00, load_ready=1 after release, no load_err.

Source files
------------

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared BCD limits, FSM encoding and load range check for time_keeper
package clock_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] UNITS_MAX           = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_MAX_TENS        = 4'd5;
    localparam logic [DIGIT_W-1:0] HOUR_MAX_TENS       = 4'd2;
    localparam logic [DIGIT_W-1:0] HOUR_MAX_UNITS_AT_2 = 4'd3;

    typedef logic [2*DIGIT_W-1:0] bcd2_t;

    typedef enum logic {
        RUN   = 1'b0,
        CHECK = 1'b1
    } state_t;

    function automatic logic time_valid(input bcd2_t h, input bcd2_t m, input bcd2_t s);
        return (h[3:0] <= UNITS_MAX) && (m[3:0] <= UNITS_MAX) && (s[3:0] <= UNITS_MAX) &&
               (m[7:4] <= SEC_MAX_TENS) && (s[7:4] <= SEC_MAX_TENS) &&
               (h[7:4] <= HOUR_MAX_TENS) &&
               !((h[7:4] == HOUR_MAX_TENS) && (h[3:0] > HOUR_MAX_UNITS_AT_2));
    endfunction

endpackage

// File: rtl/time_keeper_if.sv
// rtl/time_keeper_if.sv - time-set load handshake between a setter and time_keeper
interface time_keeper_if;
    import clock_pkg::*;

    logic  load_valid;
    logic  load_ready;
    bcd2_t load_hh;
    bcd2_t load_mm;
    bcd2_t load_ss;
    logic  load_err;

    modport master (output load_valid, load_hh, load_mm, load_ss, input load_ready, load_err);
    modport slave  (input load_valid, load_hh, load_mm, load_ss, output load_ready, load_err);
endinterface

// File: rtl/tick_sync.sv
// rtl/tick_sync.sv - synchronizer, post-reset arming and edge detector producing tick_evt
module tick_sync #(
    parameter int SYNC_STAGES = 2,
    parameter bit BOTH_EDGES  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic tick_evt
);
    localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [2:0]             arm_cnt;
    logic                   prev;
    logic                   sync_out;
    logic                   armed;
    logic                   edge_raw;

    assign sync_out = sync[SYNC_STAGES-1];
    assign armed    = (arm_cnt == ARM_CYCLES);
    assign edge_raw = BOTH_EDGES ? (sync_out ^ prev) : (sync_out & ~prev);

    // prev follows the synchronizer during arming so a high tick_in at reset release is not an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= '0;
            arm_cnt  <= '0;
            prev     <= 1'b0;
            tick_evt <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], tick_in};
            prev     <= sync_out;
            tick_evt <= armed & edge_raw;
            if (!armed)
                arm_cnt <= arm_cnt + 3'd1;
        end
    end
endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - BCD 24-hour time of day driven by a 1 Hz tick, with checked time-set load
module time_keeper
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit BOTH_EDGES  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick_in,
    time_keeper_if.slave  load,
    output bcd2_t         hh,
    output bcd2_t         mm,
    output bcd2_t         ss,
    output logic          sec_pulse,
    output logic          min_pulse,
    output logic          hour_pulse,
    output logic          day_pulse
);
    state_t state, state_nxt;
    logic   ready;
    logic   accept;
    logic   tick_evt;
    logic   inc;
    logic   ss_wrap, mm_wrap, hh_wrap;
    bcd2_t  cap_hh, cap_mm, cap_ss;
    bcd2_t  ss_nxt, mm_nxt, hh_nxt;

    tick_sync #(.SYNC_STAGES(SYNC_STAGES), .BOTH_EDGES(BOTH_EDGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .tick_in  (tick_in),
        .tick_evt (tick_evt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            RUN: begin
                ready = 1'b1;
                if (load.load_valid) state_nxt = CHECK;
            end
            CHECK:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign load.load_ready = ready;
    assign accept          = load.load_valid && ready;
    // a second arriving while a load is being accepted or checked is dropped; the load wins
    assign inc             = tick_evt && (state == RUN) && !accept;

    assign ss_wrap = (ss == 8'h59);
    assign mm_wrap = (mm == 8'h59);
    assign hh_wrap = (hh == 8'h23);

    always_comb begin
        ss_nxt = ss;
        mm_nxt = mm;
        hh_nxt = hh;
        if (ss_wrap)              ss_nxt = 8'h00;
        else if (ss[3:0] == 4'd9) ss_nxt = {ss[7:4] + 4'd1, 4'd0};
        else                      ss_nxt = {ss[7:4], ss[3:0] + 4'd1};
        if (mm_wrap)              mm_nxt = 8'h00;
        else if (mm[3:0] == 4'd9) mm_nxt = {mm[7:4] + 4'd1, 4'd0};
        else                      mm_nxt = {mm[7:4], mm[3:0] + 4'd1};
        if (hh_wrap)              hh_nxt = 8'h00;
        else if (hh[3:0] == 4'd9) hh_nxt = {hh[7:4] + 4'd1, 4'd0};
        else                      hh_nxt = {hh[7:4], hh[3:0] + 4'd1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hh            <= 8'h00;
            mm            <= 8'h00;
            ss            <= 8'h00;
            cap_hh        <= 8'h00;
            cap_mm        <= 8'h00;
            cap_ss        <= 8'h00;
            sec_pulse     <= 1'b0;
            min_pulse     <= 1'b0;
            hour_pulse    <= 1'b0;
            day_pulse     <= 1'b0;
            load.load_err <= 1'b0;
        end else begin
            sec_pulse     <= inc;
            min_pulse     <= inc && ss_wrap;
            hour_pulse    <= inc && ss_wrap && mm_wrap;
            day_pulse     <= inc && ss_wrap && mm_wrap && hh_wrap;
            load.load_err <= 1'b0;
            if (accept) begin
                cap_hh <= load.load_hh;
                cap_mm <= load.load_mm;
                cap_ss <= load.load_ss;
            end
            if (state == CHECK) begin
                if (time_valid(cap_hh, cap_mm, cap_ss)) begin
                    hh <= cap_hh;
                    mm <= cap_mm;
                    ss <= cap_ss;
                end else begin
                    load.load_err <= 1'b1;
                end
            end else if (inc) begin
                ss <= ss_nxt;
                if (ss_wrap) mm <= mm_nxt;
                if (ss_wrap && mm_wrap) hh <= hh_nxt;
            end
        end
    end
endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - directed self-checking bench for time_keeper in both edge modes
module tb_time_keeper;
    import clock_pkg::*;

    logic clk = 1'b0;
    logic rst1, rst0;
    logic tick1, tick0;
    bcd2_t hh1, mm1, ss1, hh0, mm0, ss0;
    logic sp1, mp1, hp1, dp1, sp0, mp0, hp0, dp0;
    int checks = 0;
    int errors = 0;

    time_keeper_if if1 ();
    time_keeper_if if0 ();

    always #5 clk = ~clk;

    time_keeper #(.SYNC_STAGES(2), .BOTH_EDGES(1'b1)) u1 (
        .clk(clk), .rst(rst1), .tick_in(tick1), .load(if1.slave),
        .hh(hh1), .mm(mm1), .ss(ss1),
        .sec_pulse(sp1), .min_pulse(mp1), .hour_pulse(hp1), .day_pulse(dp1)
    );

    time_keeper #(.SYNC_STAGES(2), .BOTH_EDGES(1'b0)) u0 (
        .clk(clk), .rst(rst0), .tick_in(tick0), .load(if0.slave),
        .hh(hh0), .mm(mm0), .ss(ss0),
        .sec_pulse(sp0), .min_pulse(mp0), .hour_pulse(hp0), .day_pulse(dp0)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_time1(input string tag, input bcd2_t h, input bcd2_t m, input bcd2_t s);
        chk({tag, "_hh"}, hh1, h);
        chk({tag, "_mm"}, mm1, m);
        chk({tag, "_ss"}, ss1, s);
    endtask

    task automatic chk_pulses1(input string tag, input logic [3:0] exp);
        chk({tag, "_pulses"}, {4'h0, sp1, mp1, hp1, dp1}, {4'h0, exp});
    endtask

    task automatic tog1();
        tick1 = ~tick1;
        step(4);
    endtask

    task automatic tog0();
        tick0 = ~tick0;
        step(4);
    endtask

    task automatic load1(input string tag, input bcd2_t h, input bcd2_t m, input bcd2_t s, input logic exp_err);
        if1.load_hh = h;
        if1.load_mm = m;
        if1.load_ss = s;
        if1.load_valid = 1'b1;
        chk({tag, "_ready_run"}, if1.load_ready, 8'h01);
        step(1);
        if1.load_valid = 1'b0;
        if1.load_hh = 8'h11;
        if1.load_mm = 8'h11;
        if1.load_ss = 8'h11;
        chk({tag, "_ready_check"}, if1.load_ready, 8'h00);
        step(1);
        chk({tag, "_err"}, if1.load_err, {7'd0, exp_err});
        chk_pulses1(tag, 4'b0000);
        step(1);
        chk({tag, "_err_drop"}, if1.load_err, 8'h00);
    endtask

    initial begin
        rst1 = 1'b1; rst0 = 1'b1;
        tick1 = 1'b1; tick0 = 1'b0;
        if1.load_valid = 1'b0; if1.load_hh = '0; if1.load_mm = '0; if1.load_ss = '0;
        if0.load_valid = 1'b0; if0.load_hh = '0; if0.load_mm = '0; if0.load_ss = '0;
        step(2);
        chk_time1("reset", 8'h00, 8'h00, 8'h00);
        chk_pulses1("reset", 4'b0000);
        chk("reset_err", if1.load_err, 8'h00);
        chk("reset_ready", if1.load_ready, 8'h01);

        rst1 = 1'b0; rst0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("no_spurious_sec", sp1, 8'h00);
        end
        chk("no_spurious_ss", ss1, 8'h00);

        tick1 = 1'b0;
        step(3);
        chk("latency_early_ss", ss1, 8'h00);
        step(1);
        chk("latency_ss", ss1, 8'h01);
        chk_pulses1("latency", 4'b1000);
        step(1);
        chk("sec_pulse_one_cycle", sp1, 8'h00);

        load1("load_235958", 8'h23, 8'h59, 8'h58, 1'b0);
        chk_time1("loaded_235958", 8'h23, 8'h59, 8'h58);
        tog1();
        chk_time1("t_235959", 8'h23, 8'h59, 8'h59);
        chk_pulses1("t_235959", 4'b1000);
        tog1();
        chk_time1("day_wrap", 8'h00, 8'h00, 8'h00);
        chk_pulses1("day_wrap", 4'b1111);
        step(1);
        chk_pulses1("day_wrap_after", 4'b0000);

        load1("load_095959", 8'h09, 8'h59, 8'h59, 1'b0);
        tog1();
        chk_time1("t_100000", 8'h10, 8'h00, 8'h00);
        chk_pulses1("t_100000", 4'b1110);

        load1("load_195959", 8'h19, 8'h59, 8'h59, 1'b0);
        tog1();
        chk_time1("t_200000", 8'h20, 8'h00, 8'h00);
        chk_pulses1("t_200000", 4'b1110);

        load1("bad_24", 8'h24, 8'h00, 8'h00, 1'b1);
        chk_time1("bad_24_keep", 8'h20, 8'h00, 8'h00);
        load1("bad_60", 8'h12, 8'h60, 8'h00, 1'b1);
        chk_time1("bad_60_keep", 8'h20, 8'h00, 8'h00);
        load1("bad_1a", 8'h1A, 8'h00, 8'h00, 1'b1);
        chk_time1("bad_1a_keep", 8'h20, 8'h00, 8'h00);

        tick1 = ~tick1;
        step(3);
        if1.load_hh = 8'h08; if1.load_mm = 8'h30; if1.load_ss = 8'h00;
        if1.load_valid = 1'b1;
        chk("coinc_ready", if1.load_ready, 8'h01);
        step(1);
        if1.load_valid = 1'b0;
        chk("coinc_accept_ss", ss1, 8'h00);
        chk("coinc_accept_sec", sp1, 8'h00);
        step(1);
        chk_time1("coinc_loaded", 8'h08, 8'h30, 8'h00);
        chk_pulses1("coinc_loaded", 4'b0000);
        chk("coinc_err", if1.load_err, 8'h00);
        tog1();
        chk_time1("coinc_next", 8'h08, 8'h30, 8'h01);
        chk_pulses1("coinc_next", 4'b1000);

        tog0();
        chk("rise_ss_1", ss0, 8'h01);
        chk("rise_sec_1", sp0, 8'h01);
        tog0();
        chk("fall_ss_1", ss0, 8'h01);
        chk("fall_sec", sp0, 8'h00);
        tog0();
        tog0();
        chk("rise_ss_2", ss0, 8'h02);

        if0.load_hh = 8'h12; if0.load_mm = 8'h34; if0.load_ss = 8'h56;
        if0.load_valid = 1'b1;
        step(1);
        if0.load_valid = 1'b0;
        chk("rst_check_ready", if0.load_ready, 8'h00);
        #2 rst0 = 1'b1;
        #1;
        chk("rst_async_hh", hh0, 8'h00);
        chk("rst_async_ss", ss0, 8'h00);
        step(1);
        rst0 = 1'b0;
        step(1);
        chk("rst_after_ready", if0.load_ready, 8'h01);
        chk("rst_after_err", if0.load_err, 8'h00);
        chk("rst_after_time", {hh0 | mm0 | ss0}, 8'h00);
        step(1);
        chk("rst_after_err2", if0.load_err, 8'h00);
        chk("rst_after_hh2", hh0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
